// File: rtl/mux16_arbiter.sv
// Round-robin arbiter for 16 requesters driving a shared 16:1 mux select.
// Grants are held until done/req-drop/watchdog, with one idle turnaround cycle between grants.
module mux16_arbiter #(
  parameter int MAX_HOLD = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] done,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         WD_EN     = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = WD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t      state, state_nxt;
  logic [3:0]  last, last_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [15:0] gnt_nxt;
  logic [3:0]  sel_nxt;
  logic        busy_nxt;
  logic        timeout_nxt;
  logic        owner_release;
  logic        wd_expire;
  logic [3:0]  pick;

  // Search starts one past the last owner, so the last owner is considered last.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] base);
    logic [3:0] idx;
    logic [3:0] found_idx;
    logic       found;
    found_idx = base;
    found     = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = base + 4'(k);
      if (!found && r[idx]) begin
        found_idx = idx;
        found     = 1'b1;
      end
    end
    return found_idx;
  endfunction

  assign pick          = rr_pick(req, last);
  assign owner_release = done[sel] || !req[sel];
  assign wd_expire     = WD_EN && (hold_cnt == HOLD_LAST);

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred; blocking '=' is correct inside always_comb.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        gnt_nxt  = 16'h0000;
        busy_nxt = 1'b0;
        if (|req) begin
          gnt_nxt   = 16'h0001 << pick;
          sel_nxt   = pick;
          busy_nxt  = 1'b1;
          hold_nxt  = 8'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // An owner-side release wins over a coincident watchdog expiry.
        if (owner_release || wd_expire) begin
          gnt_nxt     = 16'h0000;
          busy_nxt    = 1'b0;
          last_nxt    = sel;
          state_nxt   = IDLE;
          timeout_nxt = !owner_release;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 16'h0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values; the async reset clears all outputs without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 4'd15;
      hold_cnt <= 8'd0;
      gnt      <= 16'h0000;
      sel      <= 4'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: directed scenarios plus randomized traffic checked against
// a cycle-level reference model, on a watchdog build (MAX_HOLD=4) and a no-watchdog build.
module tb_mux16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] done;

  logic [15:0] gnt_w [2];
  logic [3:0]  sel_w [2];
  logic        busy_w [2];
  logic        to_w [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance: owner, grant age in cycles, rotation pointer.
  int m_max [2] = '{4, 0};
  int m_busy [2];
  int m_owner [2];
  int m_last [2];
  int m_held [2];
  int m_to [2];

  always #5 clk = ~clk;

  mux16_arbiter #(.MAX_HOLD(4)) dut_wd (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_w[0]), .sel(sel_w[0]), .busy(busy_w[0]), .timeout(to_w[0])
  );

  mux16_arbiter #(.MAX_HOLD(0)) dut_nowd (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_w[1]), .sel(sel_w[1]), .busy(busy_w[1]), .timeout(to_w[1])
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_after(input logic [15:0] r, input int from);
    int res;
    int j;
    res = -1;
    for (int k = 1; k <= 16; k++) begin
      j = (from + k) % 16;
      if (res < 0 && r[j]) res = j;
    end
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]  = 0;
        m_owner[i] = 0;
        m_last[i]  = 15;
        m_held[i]  = 0;
        m_to[i]    = 0;
      end else begin
        m_to[i] = 0;
        if (m_busy[i] == 0) begin
          if (req != 16'h0) begin
            m_owner[i] = first_after(req, m_last[i]);
            m_busy[i]  = 1;
            m_held[i]  = 1;
          end
        end else if (done[m_owner[i]] || !req[m_owner[i]]) begin
          m_busy[i] = 0;
          m_last[i] = m_owner[i];
        end else if (m_max[i] != 0 && m_held[i] == m_max[i]) begin
          m_busy[i] = 0;
          m_last[i] = m_owner[i];
          m_to[i]   = 1;
        end else begin
          m_held[i]++;
        end
      end
    end
  end

  task automatic compare_model();
    logic [15:0] exp_gnt;
    for (int i = 0; i < 2; i++) begin
      exp_gnt = (m_busy[i] != 0) ? (16'h0001 << m_owner[i]) : 16'h0000;
      check($sformatf("model_gnt%0d", i), gnt_w[i], exp_gnt);
      check($sformatf("model_sel%0d", i), 16'(sel_w[i]), 16'(m_owner[i]));
      check($sformatf("model_busy%0d", i), 16'(busy_w[i]), 16'(m_busy[i]));
      check($sformatf("model_timeout%0d", i), 16'(to_w[i]), 16'(m_to[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    logic [15:0] exp_oh;
    rst  = 1'b1;
    req  = 16'h0;
    done = 16'h0;
    repeat (2) tick();
    check("rst_gnt", gnt_w[0], 16'h0);
    check("rst_sel", 16'(sel_w[0]), 16'h0);
    check("rst_busy", 16'(busy_w[0]), 16'h0);
    check("rst_timeout", 16'(to_w[0]), 16'h0);
    rst = 1'b0;

    // Single requester: grant, then done release.
    req = 16'h0001;
    tick();
    check("first_gnt", gnt_w[0], 16'h0001);
    check("first_busy", 16'(busy_w[0]), 16'h1);
    done = 16'h0001;
    tick();
    check("done_rel_gnt", gnt_w[0], 16'h0);
    check("done_rel_sel", 16'(sel_w[0]), 16'h0);
    done = 16'h0;
    req  = 16'h0;
    tick();

    // Watchdog expiry after 4 cycles, then the next requester.
    req = 16'h0024;
    tick();
    check("wd_gnt_c1", gnt_w[0], 16'h0004);
    repeat (3) tick();
    check("wd_gnt_c4", gnt_w[0], 16'h0004);
    tick();
    check("wd_rel_gnt", gnt_w[0], 16'h0);
    check("wd_timeout", 16'(to_w[0]), 16'h1);
    check("nowd_still_held", gnt_w[1], 16'h0004);
    tick();
    check("wd_next_gnt", gnt_w[0], 16'h0020);
    check("wd_timeout_clr", 16'(to_w[0]), 16'h0);

    // done coincident with watchdog expiry: plain release.
    req = 16'h0004;
    repeat (2) tick();
    check("wd2_gnt", gnt_w[0], 16'h0004);
    repeat (3) tick();
    done = 16'h0004;
    tick();
    check("wd2_rel_gnt", gnt_w[0], 16'h0);
    check("wd2_no_timeout", 16'(to_w[0]), 16'h0);
    done = 16'h0;
    req  = 16'h0;
    tick();

    // Foreign done/req activity must not disturb the owner.
    req = 16'h0020;
    tick();
    check("spur_gnt", gnt_w[0], 16'h0020);
    done = 16'h0080;
    req  = 16'h0220;
    tick();
    check("spur_hold", gnt_w[0], 16'h0020);
    done = 16'h0;
    req  = 16'h0200;
    tick();
    check("spur_drop_rel", gnt_w[0], 16'h0);
    tick();
    check("spur_next", gnt_w[0], 16'h0200);

    // Wrap-around of the rotation pointer.
    req = 16'h4000;
    repeat (2) tick();
    check("wrap_14", gnt_w[0], 16'h4000);
    req = 16'h8008;
    repeat (2) tick();
    check("wrap_15", gnt_w[0], 16'h8000);
    done = 16'h8000;
    tick();
    done = 16'h0;
    tick();
    check("wrap_3", gnt_w[0], 16'h0008);
    req  = 16'h0009;
    done = 16'h0008;
    tick();
    done = 16'h0;
    tick();
    check("wrap_0", gnt_w[0], 16'h0001);

    // Asynchronous reset between clock edges.
    req = 16'h1000;
    repeat (2) tick();
    check("arst_pre_gnt", gnt_w[0], 16'h1000);
    #3 rst = 1'b1;
    #1;
    check("arst_gnt", gnt_w[0], 16'h0);
    check("arst_sel", 16'(sel_w[0]), 16'h0);
    check("arst_busy", 16'(busy_w[0]), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 16'h1001;
    tick();
    check("arst_first", gnt_w[0], 16'h0001);

    // Full rotation with req=0xFFFF, done after 3 grant cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 16'hFFFF;
    for (int g = 0; g <= 16; g++) begin
      tick();
      exp_oh = 16'h0001 << (g % 16);
      check($sformatf("rot_gnt%0d", g), gnt_w[0], exp_oh);
      repeat (2) tick();
      done = exp_oh;
      tick();
      check($sformatf("rot_idle%0d", g), 16'(busy_w[0]), 16'h0);
      done = 16'h0;
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) req = req ^ (16'h0001 << $urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) req = 16'($urandom);
      done = 16'h0;
      if ($urandom_range(0, 5) == 0) done[m_owner[0]] = 1'b1;
      if ($urandom_range(0, 3) == 0) done[$urandom_range(0, 15)] = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
